vote_button_control: RTL and testbench

VOTE_BUTTON_CONTROL -- requirements
Module: vote_button_control

---
 rtl/vote_button_control.sv | 127 ++++++++++++
 tb/tb_vote_button_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vote_button_control.sv
// Debounces four raw candidate buttons. It emits one registered vote pulse for each clean single-button press,
// or a one-cycle invalid_press pulse when more than one button is pressed at the same time.
module vote_button_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic mode,
  input  logic button1,
  input  logic button2,
  input  logic button3,
  input  logic button4,
  output logic candi1_vote_valid,
  output logic candi2_vote_valid,
  output logic candi3_vote_valid,
  output logic candi4_vote_valid,
  output logic invalid_press,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    VOTE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  latch_q, latch_d;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  vote_q, vote_d;
  logic        invalid_q, invalid_d;
  logic [3:0]  pat;
  logic        pat_onehot;

  assign pat        = sync2_q;
  assign pat_onehot = (pat != 4'd0) && ((pat & (pat - 4'd1)) == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      latch_q   <= 4'd0;
      sync1_q   <= 4'd0;
      sync2_q   <= 4'd0;
      vote_q    <= 4'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      sync1_q   <= {button4, button3, button2, button1};
      sync2_q   <= sync1_q;
      vote_q    <= vote_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_d   = latch_q;
    vote_d    = 4'd0;
    invalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode && pat != 4'd0) begin
          cnt_d = 16'd0;
          if (pat_onehot) begin
            state_d = DEBOUNCE;
            latch_d = pat;
          end else begin
            state_d   = WAIT_RELEASE;
            invalid_d = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        // Leaving voting mode abandons the press, but the release must still be debounced.
        if (mode) begin
          state_d = WAIT_RELEASE;
          cnt_d   = 16'd0;
        end else if (pat == latch_q) begin
          if (cnt_q == CNT_MAX) begin
            state_d = VOTE;
            vote_d  = latch_q;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (pat == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d   = WAIT_RELEASE;
          invalid_d = 1'b1;
          cnt_d     = 16'd0;
        end
      end
      VOTE: begin
        state_d = WAIT_RELEASE;
        cnt_d   = 16'd0;
      end
      WAIT_RELEASE: begin
        if (pat != 4'd0) begin
          cnt_d = 16'd0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign candi1_vote_valid = vote_q[0];
  assign candi2_vote_valid = vote_q[1];
  assign candi3_vote_valid = vote_q[2];
  assign candi4_vote_valid = vote_q[3];
  assign invalid_press     = invalid_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_vote_button_control.sv
// Scoreboard bench for vote_button_control: a reference model queues the expected outputs for every cycle,
// and an independent monitor compares them against the DUT.
module tb_vote_button_control;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode  = 1'b0;
  logic [3:0] btn   = 4'd0;
  logic       c1, c2, c3, c4, inv, busy;

  int n_vec = 0;
  int n_err = 0;
  int vcount[4];
  int icount = 0;
  logic [5:0] exp_q[$];

  vote_button_control #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
    .candi1_vote_valid(c1), .candi2_vote_valid(c2),
    .candi3_vote_valid(c3), .candi4_vote_valid(c4),
    .invalid_press(inv), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: rule-level behaviour seen through a two-stage sampling delay.
  initial begin : model
    logic [3:0] s1, s2, p, held, vote;
    int         phase;  // 0 idle, 1 counting a press, 2 voting, 3 waiting for release
    int         run;
    logic       bad;
    s1 = 0; s2 = 0; held = 0; phase = 0; run = 0;
    forever begin
      @(posedge clock);
      vote = 0;
      bad  = 0;
      p    = s2;
      if (reset) begin
        s1 = 0; s2 = 0; held = 0; phase = 0; run = 0;
      end else begin
        s2 = s1;
        s1 = btn;
        if (phase == 0) begin
          if (!mode && p != 0) begin
            run = 0;
            if ($countones(p) == 1) begin phase = 1; held = p; end
            else begin phase = 3; bad = 1; end
          end
        end else if (phase == 1) begin
          if (mode) begin phase = 3; run = 0; end
          else if (p == held) begin
            if (run == D - 1) begin phase = 2; vote = held; end
            else run++;
          end else if (p == 0) begin phase = 0; run = 0; end
          else begin phase = 3; bad = 1; run = 0; end
        end else if (phase == 2) begin
          phase = 3; run = 0;
        end else begin
          if (p != 0) run = 0;
          else if (run == D - 1) begin phase = 0; run = 0; end
          else run++;
        end
      end
      exp_q.push_back({vote, bad, phase != 0});
    end
  end

  initial begin : monitor
    logic [5:0] got, want;
    forever begin
      @(posedge clock);
      #1;
      got = {c4, c3, c2, c1, inv, busy};
      for (int k = 0; k < 4; k++) if (got[k+2]) vcount[k]++;
      if (inv) icount++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty at %0t: got %b, no expected entry", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL outputs at %0t: got vote=%b inv=%b busy=%b, expected vote=%b inv=%b busy=%b",
                   $time, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) vcount[k] = 0;
    icount = 0;
  endtask

  task automatic check_cnt(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin : stim
    @(negedge clock);
    tick(2);
    check_cnt("reset_busy", int'(busy), 0);
    check_cnt("reset_inv", int'(inv), 0);
    reset = 1'b0;
    tick(3);

    // A clean hold of button2 yields one pulse, six cycles after it is first sampled.
    clear_counts();
    btn = 4'b0010;
    tick(1);
    tick(5);
    check_cnt("b2_not_yet", vcount[1], 0);
    tick(1);
    check_cnt("b2_on_time", vcount[1], 1);
    tick(13);
    btn = 4'b0000;
    tick(5);
    check_cnt("b2_busy_before_release_done", int'(busy), 1);
    tick(1);
    check_cnt("b2_busy_cleared", int'(busy), 0);
    check_cnt("b2_single_pulse", vcount[1], 1);
    tick(4);

    // A bouncing button must never be counted.
    clear_counts();
    for (int i = 0; i < 10; i++) begin btn = 4'b0001; tick(2); btn = 4'b0000; tick(2); end
    tick(10);
    check_cnt("bounce_no_vote", vcount[0] + vcount[1] + vcount[2] + vcount[3], 0);
    check_cnt("bounce_idle", int'(busy), 0);

    // Two buttons together are rejected; a later single press is still accepted.
    clear_counts();
    btn = 4'b0101;
    tick(8);
    btn = 4'b0000;
    tick(10);
    check_cnt("multi_invalid_once", icount, 1);
    check_cnt("multi_no_vote", vcount[0] + vcount[1] + vcount[2] + vcount[3], 0);
    btn = 4'b1000;
    tick(10);
    btn = 4'b0000;
    tick(10);
    check_cnt("after_multi_b4", vcount[3], 1);

    // In display mode nothing is recorded, including when the mode changes during debounce.
    clear_counts();
    mode = 1'b1;
    btn = 4'b1000;
    tick(10);
    btn = 4'b0000;
    tick(10);
    mode = 1'b0;
    btn = 4'b0100;
    tick(4);
    mode = 1'b1;
    tick(6);
    check_cnt("mode_busy_held", int'(busy), 1);
    btn = 4'b0000;
    tick(10);
    check_cnt("mode_no_output", vcount[0] + vcount[1] + vcount[2] + vcount[3] + icount, 0);
    check_cnt("mode_idle", int'(busy), 0);
    mode = 1'b0;

    // A reset in the middle of debouncing drops the press; the still-held button is a fresh press.
    clear_counts();
    btn = 4'b0001;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_cnt("rst_busy", int'(busy), 0);
    tick(6);
    check_cnt("rst_no_early", vcount[0], 0);
    tick(1);
    check_cnt("rst_fresh_press", vcount[0], 1);
    btn = 4'b0000;
    tick(10);

    // Ten clean presses into a downstream tally.
    clear_counts();
    for (int i = 0; i < 10; i++) begin btn = 4'b0100; tick(9); btn = 4'b0000; tick(8); end
    check_cnt("tally_c3", vcount[2], 10);
    check_cnt("tally_others", vcount[0] + vcount[1] + vcount[3], 0);

    // Random patterns, hold times, mode changes and resets.
    for (int s = 0; s < 400; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) btn = 4'b0000;
      else if (r < 8) btn = 4'b0001 << $urandom_range(0, 3);
      else btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) begin reset = 1'b1; tick(1); reset = 1'b0; end
      tick($urandom_range(1, 14));
    end
    btn = 4'b0000;
    mode = 1'b0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
